// File: rtl/wb_unit_pkg.sv
// Shared CPU definitions used by the write-back stage: load formats,
// instruction source types and write-back FSM state encodings.
package wb_unit_pkg;

   typedef enum logic [2:0] {
      FMT_LB  = 3'b000,
      FMT_LH  = 3'b001,
      FMT_LW  = 3'b010,
      FMT_LD  = 3'b011,
      FMT_LBU = 3'b100,
      FMT_LHU = 3'b101,
      FMT_LWU = 3'b110
   } ld_fmt_e;

   typedef enum logic [1:0] {
      INST_ALU  = 2'd0,
      INST_LOAD = 2'd1,
      INST_LINK = 2'd2
   } inst_type_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_RSP = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_unit_load_align.sv
// Load data alignment: shift the raw aligned word down to the addressed
// byte lane, then sign- or zero-extend according to the funct3 load format.
module load_align
   import wb_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]                 i_fmt,
   input  logic [$clog2(XLEN/8)-1:0]  i_byte_off,
   input  logic [XLEN-1:0]            i_data,
   output logic [XLEN-1:0]            o_data
);

   logic [XLEN-1:0] w_shifted;

   always_comb begin
      w_shifted = i_data >> {i_byte_off, 3'b000};
      case (ld_fmt_e'(i_fmt))
         FMT_LB:  o_data = XLEN'($signed(w_shifted[7:0]));
         FMT_LH:  o_data = XLEN'($signed(w_shifted[15:0]));
         FMT_LW:  o_data = XLEN'($signed(w_shifted[31:0]));
         FMT_LBU: o_data = XLEN'(w_shifted[7:0]);
         FMT_LHU: o_data = XLEN'(w_shifted[15:0]);
         FMT_LWU: o_data = XLEN'(w_shifted[31:0]);
         // LD only meaningful for XLEN=64, where it is the full shifted word
         FMT_LD:  o_data = w_shifted;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: accepts MEM results, waits for outstanding load data,
// and produces a registered register-file write that doubles as forwarding bus.
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RF_AW    = 5,
   parameter int unsigned LINK_INC = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [RF_AW-1:0]           in_rd,
   input  logic                       in_we,
   input  logic                       in_is_load,
   input  logic                       in_is_link,
   input  logic [2:0]                 in_ld_fmt,
   input  logic [$clog2(XLEN/8)-1:0]  in_byte_off,
   input  logic [XLEN-1:0]            in_alu_out,
   input  logic [XLEN-1:0]            in_pc,
   input  logic                       dram_rsp_valid,
   input  logic [XLEN-1:0]            dram_rsp_data,
   input  logic                       flush,
   output logic                       rf_wr_en,
   output logic [RF_AW-1:0]           rf_wr_addr,
   output logic [XLEN-1:0]            rf_wr_data,
   output logic                       wb_busy
);

   localparam int unsigned OFFW = $clog2(XLEN/8);

   wb_state_e         r_state, w_state_nxt;
   logic              r_drop, w_drop_nxt;
   logic              r_wr_en, w_wr_en_nxt;
   logic [RF_AW-1:0]  r_wr_addr, w_wr_addr_nxt;
   logic [XLEN-1:0]   r_wr_data, w_wr_data_nxt;
   logic [RF_AW-1:0]  r_ld_rd;
   logic              r_ld_we;
   logic [2:0]        r_ld_fmt;
   logic [OFFW-1:0]   r_ld_off;

   logic              w_accept;
   logic              w_latch;
   inst_type_e        w_src;
   logic [2:0]        w_al_fmt;
   logic [OFFW-1:0]   w_al_off;
   logic [XLEN-1:0]   w_aligned;

   assign in_ready   = (r_state == ST_IDLE) && !flush;
   assign w_accept   = in_valid && in_ready;
   assign wb_busy    = (r_state == ST_WAIT_RSP);
   assign rf_wr_en   = r_wr_en;
   assign rf_wr_addr = r_wr_addr;
   assign rf_wr_data = r_wr_data;

   // Latched context drives the aligner while waiting; otherwise the live inputs
   assign w_al_fmt = (r_state == ST_WAIT_RSP) ? r_ld_fmt : in_ld_fmt;
   assign w_al_off = (r_state == ST_WAIT_RSP) ? r_ld_off : in_byte_off;

   load_align #(.XLEN(XLEN)) u_load_align (
      .i_fmt      (w_al_fmt),
      .i_byte_off (w_al_off),
      .i_data     (dram_rsp_data),
      .o_data     (w_aligned)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_drop_nxt    = r_drop;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_latch       = 1'b0;
      w_src         = INST_ALU;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_src = in_is_load ? INST_LOAD : (in_is_link ? INST_LINK : INST_ALU);
               if (in_is_load && !dram_rsp_valid) begin
                  w_state_nxt = ST_WAIT_RSP;
                  w_drop_nxt  = 1'b0;
                  w_latch     = 1'b1;
               end else begin
                  w_wr_en_nxt = in_we && (in_rd != '0);
               end
            end
         end
         ST_WAIT_RSP: begin
            if (flush) w_drop_nxt = 1'b1;
            if (dram_rsp_valid) begin
               // A flush coinciding with the response squashes it as well
               w_src       = INST_LOAD;
               w_state_nxt = ST_IDLE;
               w_drop_nxt  = 1'b0;
               w_wr_en_nxt = r_ld_we && (r_ld_rd != '0) && !r_drop && !flush;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_wr_en_nxt) begin
         w_wr_addr_nxt = (r_state == ST_WAIT_RSP) ? r_ld_rd : in_rd;
         case (w_src)
            INST_LINK: w_wr_data_nxt = in_pc + XLEN'(LINK_INC);
            INST_LOAD: w_wr_data_nxt = w_aligned;
            default:   w_wr_data_nxt = in_alu_out;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_drop    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_drop    <= w_drop_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ld_rd  <= '0;
         r_ld_we  <= 1'b0;
         r_ld_fmt <= '0;
         r_ld_off <= '0;
      end else if (w_latch) begin
         r_ld_rd  <= in_rd;
         r_ld_we  <= in_we;
         r_ld_fmt <= in_ld_fmt;
         r_ld_off <= in_byte_off;
      end
   end

endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit (XLEN=32): ALU/link/load writes,
// late responses, flush while waiting, and reset while waiting.
module tb_wb_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_we;
   logic        in_is_load;
   logic        in_is_link;
   logic [2:0]  in_ld_fmt;
   logic [1:0]  in_byte_off;
   logic [31:0] in_alu_out;
   logic [31:0] in_pc;
   logic        dram_rsp_valid;
   logic [31:0] dram_rsp_data;
   logic        flush;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        wb_busy;

   int checks = 0;
   int errors = 0;

   wb_unit #(.XLEN(32), .RF_AW(5), .LINK_INC(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_rd          (in_rd),
      .in_we          (in_we),
      .in_is_load     (in_is_load),
      .in_is_link     (in_is_link),
      .in_ld_fmt      (in_ld_fmt),
      .in_byte_off    (in_byte_off),
      .in_alu_out     (in_alu_out),
      .in_pc          (in_pc),
      .dram_rsp_valid (dram_rsp_valid),
      .dram_rsp_data  (dram_rsp_data),
      .flush          (flush),
      .rf_wr_en       (rf_wr_en),
      .rf_wr_addr     (rf_wr_addr),
      .rf_wr_data     (rf_wr_data),
      .wb_busy        (wb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_rd = '0; in_we = 0; in_is_load = 0; in_is_link = 0;
      in_ld_fmt = '0; in_byte_off = '0; in_alu_out = '0; in_pc = '0;
      dram_rsp_valid = 0; dram_rsp_data = '0; flush = 0;
   endtask

   task automatic drive_op(input logic [4:0] rd, input logic we, input logic ld, input logic lnk,
                           input logic [2:0] fmt, input logic [1:0] off,
                           input logic [31:0] alu, input logic [31:0] pc);
      in_valid = 1; in_rd = rd; in_we = we; in_is_load = ld; in_is_link = lnk;
      in_ld_fmt = fmt; in_byte_off = off; in_alu_out = alu; in_pc = pc;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      #3;
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", rf_wr_en); end
      checks++; if (rf_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 00", rf_wr_addr); end
      checks++; if (rf_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", rf_wr_data); end
      checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", wb_busy); end
      tick();
      rst_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_alu();
      drive_op(5'd3, 1, 0, 0, 3'b000, 2'd0, 32'h0000_1234, 32'h0000_0100);
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL alu_en got %b exp 1", rf_wr_en); end
      checks++; if (rf_wr_addr !== 5'd3) begin errors++; $display("FAIL alu_addr got %h exp 03", rf_wr_addr); end
      checks++; if (rf_wr_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got %h exp 00001234", rf_wr_data); end
      tick();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_link_wrap();
      drive_op(5'd1, 1, 0, 1, 3'b000, 2'd0, 32'h1111_1111, 32'hFFFF_FFFC);
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL link_en got %b exp 1", rf_wr_en); end
      checks++; if (rf_wr_data !== 32'h0000_0000) begin errors++; $display("FAIL link_data got %h exp 00000000", rf_wr_data); end
      drive_op(5'd2, 1, 0, 1, 3'b000, 2'd0, 32'h0, 32'h0000_2000);
      tick();
      idle_inputs();
      checks++; if (rf_wr_data !== 32'h0000_2004) begin errors++; $display("FAIL link2_data got %h exp 00002004", rf_wr_data); end
   endtask

   task automatic test_suppress();
      drive_op(5'd0, 1, 0, 0, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0);
      tick();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rd0_en got %b exp 0", rf_wr_en); end
      drive_op(5'd9, 0, 0, 0, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0);
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL we0_en got %b exp 0", rf_wr_en); end
      dram_rsp_valid = 1; dram_rsp_data = 32'h1234_5678;
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL stray_idle_en got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_load_same_cycle();
      logic [2:0]  fmts [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
      logic [1:0]  offs [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
      logic [31:0] raws [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8000_0001, 32'h1234_F00F};
      logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h8000_0001, 32'h0000_F00F};
      for (int i = 0; i < 5; i++) begin
         drive_op(5'd10, 1, 1, 0, fmts[i], offs[i], 32'h0, 32'h0);
         dram_rsp_valid = 1; dram_rsp_data = raws[i];
         tick();
         idle_inputs();
         checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10 || rf_wr_data !== exps[i])
            begin errors++; $display("FAIL load_same[%0d] got en=%b addr=%h data=%h exp en=1 addr=0a data=%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, exps[i]); end
         checks++; if (in_ready !== 1'b1 || wb_busy !== 1'b0)
            begin errors++; $display("FAIL load_same_idle[%0d] got ready=%b busy=%b exp ready=1 busy=0", i, in_ready, wb_busy); end
      end
   endtask

   task automatic test_load_late();
      drive_op(5'd6, 1, 1, 0, 3'b001, 2'd2, 32'h0, 32'h0);
      tick();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         checks++; if (in_ready !== 1'b0 || wb_busy !== 1'b1 || rf_wr_en !== 1'b0)
            begin errors++; $display("FAIL late_wait[%0d] got ready=%b busy=%b en=%b exp ready=0 busy=1 en=0", c, in_ready, wb_busy, rf_wr_en); end
         if (c == 2) begin dram_rsp_valid = 1; dram_rsp_data = 32'hF00F_0000; end
         tick();
      end
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd6 || rf_wr_data !== 32'hFFFF_F00F)
         begin errors++; $display("FAIL late_write got en=%b addr=%h data=%h exp en=1 addr=06 data=fffff00f", rf_wr_en, rf_wr_addr, rf_wr_data); end
      checks++; if (in_ready !== 1'b1 || wb_busy !== 1'b0)
         begin errors++; $display("FAIL late_idle got ready=%b busy=%b exp ready=1 busy=0", in_ready, wb_busy); end
   endtask

   task automatic test_flush_wait();
      drive_op(5'd5, 1, 1, 0, 3'b010, 2'd0, 32'h0, 32'h0);
      tick();
      idle_inputs();
      flush = 1;
      tick();
      flush = 0;
      checks++; if (wb_busy !== 1'b1) begin errors++; $display("FAIL flush_busy got %b exp 1", wb_busy); end
      dram_rsp_valid = 1; dram_rsp_data = 32'hCAFE_F00D;
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL flush_nowrite got %b exp 0", rf_wr_en); end
      checks++; if (in_ready !== 1'b1 || wb_busy !== 1'b0)
         begin errors++; $display("FAIL flush_idle got ready=%b busy=%b exp ready=1 busy=0", in_ready, wb_busy); end
      drive_op(5'd7, 1, 0, 0, 3'b000, 2'd0, 32'h0000_ABCD, 32'h0);
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h0000_ABCD)
         begin errors++; $display("FAIL flush_next got en=%b addr=%h data=%h exp en=1 addr=07 data=0000abcd", rf_wr_en, rf_wr_addr, rf_wr_data); end
   endtask

   task automatic test_flush_idle();
      drive_op(5'd8, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0055, 32'h0);
      tick();
      flush = 1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %b exp 0", in_ready); end
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'h0000_0055)
         begin errors++; $display("FAIL flush_idle_pending got en=%b data=%h exp en=1 data=00000055", rf_wr_en, rf_wr_data); end
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL flush_idle_accept got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_back_to_back();
      drive_op(5'd2, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0011, 32'h0);
      tick();
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd2 || rf_wr_data !== 32'h0000_0011)
         begin errors++; $display("FAIL b2b_first got en=%b addr=%h data=%h exp en=1 addr=02 data=00000011", rf_wr_en, rf_wr_addr, rf_wr_data); end
      drive_op(5'd4, 1, 0, 0, 3'b000, 2'd0, 32'h0000_0022, 32'h0);
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 32'h0000_0022)
         begin errors++; $display("FAIL b2b_second got en=%b addr=%h data=%h exp en=1 addr=04 data=00000022", rf_wr_en, rf_wr_addr, rf_wr_data); end
   endtask

   task automatic test_reset_mid_wait();
      drive_op(5'd12, 1, 0, 0, 3'b000, 2'd0, 32'h0000_7777, 32'h0);
      tick();
      drive_op(5'd13, 1, 1, 0, 3'b010, 2'd0, 32'h0, 32'h0);
      tick();
      idle_inputs();
      checks++; if (wb_busy !== 1'b1 || rf_wr_data !== 32'h0000_7777)
         begin errors++; $display("FAIL rstw_pre got busy=%b data=%h exp busy=1 data=00007777", wb_busy, rf_wr_data); end
      #2;
      rst_n = 0;
      #1;
      checks++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h0 || wb_busy !== 1'b0)
         begin errors++; $display("FAIL rstw_async got en=%b addr=%h data=%h busy=%b exp all zero", rf_wr_en, rf_wr_addr, rf_wr_data, wb_busy); end
      tick();
      rst_n = 1;
      dram_rsp_valid = 1; dram_rsp_data = 32'h5555_AAAA;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready got %b exp 1", in_ready); end
      tick();
      idle_inputs();
      checks++; if (rf_wr_en !== 1'b0 || rf_wr_data !== 32'h0 || wb_busy !== 1'b0)
         begin errors++; $display("FAIL rstw_stray got en=%b data=%h busy=%b exp en=0 data=0 busy=0", rf_wr_en, rf_wr_data, wb_busy); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_link_wrap();
      test_suppress();
      test_load_same_cycle();
      test_load_late();
      test_flush_wait();
      test_flush_idle();
      test_back_to_back();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
